// File: rtl/systema_btn_if.sv
// ---------------------------------------------------------------------------
// systema_btn_if
//   Avalon-MM slave bus bundle for the systema button/switch PIO.
//
//   address    [1:0]   register select
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata  [31:0]  write data
//   readdata   [31:0]  registered read data (1-clock latency)
//
//   modport master : interconnect / bus driver side
//   modport slave  : PIO side
// ---------------------------------------------------------------------------
interface systema_btn_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/systema_btn_pio.sv
// ---------------------------------------------------------------------------
// systema_btn_pio
//   Parametrised Avalon-MM input PIO for push-buttons and switches.
//   in_port is synchronised, optionally debounced per bit, edge-detected with
//   a per-bit rising/falling select, and captured into a write-1-to-clear
//   register. irq is the OR of captured edges under the interrupt mask.
//
//   Optional feature macro: SYSTEMA_BTN_DEBOUNCE_EN
//     defined   : per-bit debounce, DEBOUNCE_CYCLES stable clocks to accept
//     undefined : stable state follows the synchroniser output directly
//
//   Ports
//     clk       system clock
//     reset_n   asynchronous active-low reset
//     bus       Avalon-MM slave (address, chipselect, write_n, writedata,
//               readdata)
//     in_port   raw asynchronous button inputs [WIDTH-1:0]
//     irq       level interrupt, active high
//
//   Register map (bits above WIDTH read 0, writes to them are ignored)
//     0 DATA         RO   debounced stable state
//     1 EDGE_SEL     RW   per bit: 0 = rising, 1 = falling
//     2 IRQ_MASK     RW
//     3 EDGE_CAPTURE W1C
// ---------------------------------------------------------------------------
module systema_btn_pio #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    systema_btn_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("systema_btn_pio: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("systema_btn_pio: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("systema_btn_pio: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE  = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_sel_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic             wr;

    assign wr    = bus.chipselect && !bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    // ---------------------------------------------------------------- sync
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    // NOTE: each stage is an individual flop (not RAM), so the whole array is
    // cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------ debounce
`ifdef SYSTEMA_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter value seen on the accepting clock; the increment on that
    // clock would make it DEBOUNCE_CYCLES, so it is replaced by the clear.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [WIDTH-1:0] stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;                   // glitch discarded
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= sync[i];           // change accepted
                    cnt_q[i]    <= '0;
                end else begin
                    // Never exceeds CNT_LAST, so it cannot wrap.
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync;
`endif

    // ------------------------------------------------------ edge detection
    assign det = ( stable & ~prev_q &  ~edge_sel_q)
               | (~stable &  prev_q &   edge_sel_q);

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            edge_sel_q     <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
        end else begin
            prev_q <= stable;
            if (wr && bus.address == ADDR_EDGE_SEL) edge_sel_q <= wdata;
            if (wr && bus.address == ADDR_IRQ_MASK) irq_mask_q <= wdata;
            // A new edge wins over a simultaneous write-1-to-clear.
            edge_capture_q <= (edge_capture_q &
                               ~((wr && bus.address == ADDR_CAPTURE) ? wdata : '0))
                            | det;
        end
    end

    // ----------------------------------------------------------- read path
    // NOTE: rd_mux gets a full default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
            ADDR_EDGE_SEL: rd_mux[WIDTH-1:0] = edge_sel_q;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
            ADDR_CAPTURE:  rd_mux[WIDTH-1:0] = edge_capture_q;
        endcase
    end

    // readdata tracks the address every clock, regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_systema_btn_pio.sv
// ---------------------------------------------------------------------------
// tb_systema_btn_pio
//   Directed scoreboard bench for systema_btn_pio (WIDTH=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4). Builds with or without SYSTEMA_BTN_DEBOUNCE_EN.
//   Stimulus is applied on falling edges; every check reflects DUT state at
//   the falling edge where it was issued. Expected read data and irq levels
//   are queued by the driver and compared by an independent monitor.
// ---------------------------------------------------------------------------
module tb_systema_btn_pio;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DCYC  = 4;
`ifdef SYSTEMA_BTN_DEBOUNCE_EN
    localparam int DEB = DCYC;
`else
    localparam int DEB = 0;
`endif
    // Clocks from in_port change to DATA change.
    localparam int L = SYNC + DEB;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    systema_btn_if bus ();

    systema_btn_pio #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DCYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    exp_t rd_q  [$];
    exp_t irq_q [$];
    logic rd_req  = 1'b0;
    logic irq_req = 1'b0;
    logic irq_snap;
    int   vectors     = 0;
    int   miscompares = 0;

    // ------------------------------------------------------------- monitor
    always @(negedge clk) irq_snap = irq;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (irq_req) begin
                if (irq_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL irq_queue_empty: irq=%0b with nothing expected", irq_snap);
                end else begin
                    exp_t e;
                    e = irq_q.pop_front();
                    vectors++;
                    if (irq_snap !== e.exp[0]) begin
                        miscompares++;
                        $display("FAIL %s: irq=%0b expected %0b", e.name, irq_snap, e.exp[0]);
                    end
                end
            end
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rd_queue_empty: readdata=0x%08h with nothing expected", bus.readdata);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    vectors++;
                    if (bus.readdata !== e.exp) begin
                        miscompares++;
                        $display("FAIL %s: readdata=0x%08h expected 0x%08h", e.name, bus.readdata, e.exp);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------- driver
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            rd_req         = 1'b0;
            irq_req        = 1'b0;
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
        end
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        rd_q.push_back(e);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        rd_req         = 1'b1;
        tick();
    endtask

    // Queues an irq check; the next consuming task completes it.
    task automatic check_irq(input logic exp, input string name);
        exp_t e;
        e.exp  = {31'd0, exp};
        e.name = name;
        irq_q.push_back(e);
        irq_req = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // 1. Reset mid-operation
        do_write(2'd2, 32'hF);
        do_write(2'd1, 32'h5);
        in_port = 4'h3;
        tick(L + 2);
        check_irq(1'b1, "pre_reset_irq");
        do_read(2'd3, 32'h2, "pre_reset_capture");
        reset_n = 1'b0;
        in_port = 4'h0;
        tick(2);
        reset_n = 1'b1;
        check_irq(1'b0, "reset_irq");
        do_read(2'd0, 32'h0, "reset_data");
        do_read(2'd1, 32'h0, "reset_edge_sel");
        do_read(2'd2, 32'h0, "reset_irq_mask");
        do_read(2'd3, 32'h0, "reset_capture");

        // Input held high through reset release gives one rising edge
        reset_n = 1'b0;
        in_port = 4'h8;
        tick(2);
        reset_n = 1'b1;
        tick(L + 1);
        check_irq(1'b0, "held_high_masked_irq");
        do_read(2'd3, 32'h8, "held_high_capture");
        do_read(2'd0, 32'h8, "held_high_data");
        do_write(2'd3, 32'h8);
        do_read(2'd3, 32'h0, "held_high_cleared");
        in_port = 4'h0;
        tick(L + 2);
        do_read(2'd3, 32'h0, "fall_not_captured");

        // 2. Basic rising edge, latency and W1C
        do_write(2'd2, 32'h1);
        in_port = 4'h1;
        tick(L - 1);
        do_read(2'd0, 32'h0, "data_before_latency");
        check_irq(1'b0, "irq_before_capture");
        do_read(2'd0, 32'h1, "data_at_latency");
        check_irq(1'b1, "irq_with_capture");
        do_read(2'd3, 32'h1, "capture_set");
        do_write(2'd3, 32'h1);
        check_irq(1'b0, "irq_after_clear");
        do_read(2'd3, 32'h0, "capture_cleared");

`ifdef SYSTEMA_BTN_DEBOUNCE_EN
        // 3. Glitch shorter than the debounce window is discarded
        in_port = 4'h3;
        tick(3);
        in_port = 4'h1;
        tick(L + 2);
        do_read(2'd0, 32'h1, "glitch_data");
        check_irq(1'b0, "glitch_irq");
        do_read(2'd3, 32'h0, "glitch_capture");
`endif

        // 4. Falling-edge select on bit 2
        do_write(2'd1, 32'h4);
        in_port = 4'h5;
        tick(L + 2);
        do_read(2'd3, 32'h0, "rise_ignored_sel_fall");
        do_read(2'd0, 32'h5, "data_bit2_high");
        in_port = 4'h1;
        tick(L + 2);
        check_irq(1'b0, "bit2_masked_irq");
        do_read(2'd3, 32'h4, "fall_captured");
        do_write(2'd3, 32'h4);

        // 5. Partial W1C and set-beats-clear collision
        do_write(2'd1, 32'h1);
        do_read(2'd3, 32'h0, "edge_sel_change_no_set");
        in_port = 4'h2;
        tick(L + 2);
        check_irq(1'b1, "irq_two_bits");
        do_read(2'd3, 32'h3, "capture_two_bits");
        do_write(2'd3, 32'h2);
        do_read(2'd3, 32'h1, "partial_clear");
        do_write(2'd3, 32'h1);
        do_read(2'd3, 32'h0, "bit0_cleared");
        in_port = 4'h3;
        tick(L + 2);
        do_read(2'd3, 32'h0, "rise_ignored_bit0");
        in_port = 4'h2;
        tick(L);
        do_write(2'd3, 32'h1);
        check_irq(1'b1, "collision_irq");
        do_read(2'd3, 32'h1, "collision_set_wins");
        do_write(2'd3, 32'h1);

        // 6. One-clock pulse on bit 3: captured without debounce, filtered with
        in_port = 4'hA;
        tick(1);
        in_port = 4'h2;
        tick(1);
        do_read(2'd3, 32'h0, "pulse_capture_early");
        do_read(2'd3, (DEB == 0) ? 32'h8 : 32'h0, "pulse_capture");
        do_read(2'd0, 32'h2, "pulse_data_returns");
        do_write(2'd3, 32'hF);

        // Register decode boundaries
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd0, 32'h2, "data_write_ignored");
        do_write(2'd2, 32'hFFFF_FFFF);
        do_read(2'd2, 32'hF, "mask_upper_bits");
        do_write(2'd1, 32'hFFFF_FFF0);
        do_read(2'd1, 32'h0, "edge_sel_upper_bits");
        check_irq(1'b0, "irq_all_masked_clear");
        do_read(2'd3, 32'h0, "capture_after_sel_write");

        tick(2);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL queue_drain: %0d reads and %0d irq checks left, expected 0",
                     rd_q.size(), irq_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
